fetch_queue: RTL and testbench

- Instruction fetch front end between the instruction ROM and the control/decode stage of the 9-bit-instruction CPU.
- Owns the fetch program counter and drives the combinational instruction ROM address.
- Prefetches 9-bit instructions into a small FIFO and hands them to decode over a valid/ready handshake.
- Flushes and redirects on jump/taken-branch requests from downstream, and stops fetching at a programmed end address.

---
 rtl/fetch_queue_if.sv | 26 ++
 rtl/fetch_queue.sv | 133 +++++++++++++
 tb/tb_fetch_queue.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: ROM address/data, redirect request and the decode-side valid/ready handshake.
interface fetch_queue_if #(
    parameter int unsigned D  = 10,
    parameter int unsigned IW = 9
);
    logic          start;
    logic [D-1:0]  rom_addr;
    logic [IW-1:0] rom_data;
    logic          jump_en;
    logic [D-1:0]  jump_target;
    logic [IW-1:0] instr_out;
    logic [D-1:0]  instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic          fetch_done;

    modport master (
        input  start, rom_data, jump_en, jump_target, instr_ready,
        output rom_addr, instr_out, instr_pc, instr_valid, fetch_done
    );

    modport slave (
        output start, rom_data, jump_en, jump_target, instr_ready,
        input  rom_addr, instr_out, instr_pc, instr_valid, fetch_done
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, prefetches into a small FIFO, flushes on redirect.
// Optional perf counters (perf_fetched/perf_flushed/perf_stall) are built when FETCH_PERF_EN is defined.
module fetch_queue #(
    parameter int unsigned D        = 10,
    parameter int unsigned IW       = 9,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned END_ADDR = 400
) (
    input  logic              clk,
    input  logic              reset,
    fetch_queue_if.master     bus
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       perf_fetched,
    output logic [15:0]       perf_flushed,
    output logic [15:0]       perf_stall
`endif
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

    state_t        state_q, state_d;
    logic [D-1:0]  fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] data_q [DEPTH];
    logic [D-1:0]  addr_q [DEPTH];

    logic valid, full, at_end, jump, push, pop;

    assign valid  = (count_q != '0);
    assign full   = (count_q == CW'(DEPTH));
    assign at_end = (fetch_pc_q == D'(END_ADDR));
    assign jump   = bus.jump_en && (state_q != IDLE);
    // A redirect discards whatever push/pop would have happened on the same edge.
    assign push   = !jump && (state_q == FETCH) && !full && !at_end;
    assign pop    = !jump && valid && bus.instr_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        case (state_q)
            IDLE:    if (bus.start) state_d = FETCH;
            FETCH:   if (at_end) state_d = HALT;
            default: state_d = state_q;
        endcase
        if (push) begin
            wr_ptr_d   = wr_ptr_q + AW'(1);
            fetch_pc_d = fetch_pc_q + D'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (jump) begin
            state_d    = (bus.jump_target == D'(END_ADDR)) ? HALT : FETCH;
            fetch_pc_d = bus.jump_target;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= bus.rom_data;
            addr_q[wr_ptr_q] <= fetch_pc_q;
        end
    end

    assign bus.rom_addr    = fetch_pc_q;
    assign bus.instr_valid = valid;
    assign bus.instr_out   = valid ? data_q[rd_ptr_q] : '0;
    assign bus.instr_pc    = valid ? addr_q[rd_ptr_q] : '0;
    assign bus.fetch_done  = (state_q == HALT) && !valid;

`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched_q, perf_fetched_d;
    logic [15:0] perf_flushed_q, perf_flushed_d;
    logic [15:0] perf_stall_q, perf_stall_d;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_flushed_d = perf_flushed_q;
        perf_stall_d   = perf_stall_q;
        if (push) perf_fetched_d = sat_add(perf_fetched_q, 16'd1);
        if (jump) perf_flushed_d = sat_add(perf_flushed_q, 16'(count_q));
        if ((state_q == FETCH) && full) perf_stall_d = sat_add(perf_stall_q, 16'd1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
    assign perf_stall   = perf_stall_q;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue built with END_ADDR=8 so the halt boundary is reachable quickly.
module tb_fetch_queue;
    localparam int unsigned D   = 10;
    localparam int unsigned IW  = 9;
    localparam int unsigned END = 8;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fetch_queue_if #(.D(D), .IW(IW)) bus ();

`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched, perf_flushed, perf_stall;
`endif

    fetch_queue #(.D(D), .IW(IW), .DEPTH(4), .END_ADDR(END)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_flushed (perf_flushed),
        .perf_stall   (perf_stall)
`endif
    );

    function automatic logic [IW-1:0] rom_fn(input logic [D-1:0] a);
        int v;
        v = int'(a) * 5 + 1;
        return IW'(v);
    endfunction

    assign bus.rom_data = rom_fn(bus.rom_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n;
        logic          start;
        logic          jen;
        logic [D-1:0]  jt;
        logic          rdy;
        logic          ev;
        logic [D-1:0]  epc;
        logic [IW-1:0] eout;
        logic [D-1:0]  erom;
        logic          edone;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic je, input int jt,
                       input logic rd, input logic ev, input int epc, input int erom,
                       input logic ed);
        vec_t v;
        v.rst_n = r;  v.start = s;  v.jen = je;  v.jt = D'(jt);  v.rdy = rd;
        v.ev = ev;    v.epc = ev ? D'(epc) : '0;
        v.eout = ev ? rom_fn(D'(epc)) : '0;
        v.erom = D'(erom); v.edone = ed;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic je, input logic [D-1:0] jt,
                         input logic rd);
        reset = r; bus.start = s; bus.jump_en = je; bus.jump_target = jt; bus.instr_ready = rd;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);

        // reset, IDLE behaviour, then a ready-high stream
        add(0,0,0,0,1,    0,0,0,0);
        add(1,0,0,0,1,    0,0,0,0);
        add(1,0,1,'h50,1, 0,0,0,0);
        add(1,1,0,0,1,    0,0,0,0);
        add(1,1,0,0,1,    1,0,1,0);
        add(1,1,0,0,1,    1,1,2,0);
        add(1,1,0,0,1,    1,2,3,0);
        add(1,1,0,0,1,    1,3,4,0);
        add(1,0,0,0,1,    1,4,5,0);
        // back-pressure fills the queue, then drain into the END_ADDR halt
        add(0,0,0,0,0,    0,0,0,0);
        add(1,1,0,0,0,    0,0,0,0);
        for (int k = 1; k <= 10; k++) add(1,1,0,0,0, 1,0,(k < 4) ? k : 4,0);
        add(1,1,0,0,1,    1,1,4,0);
        add(1,1,0,0,1,    1,2,5,0);
        add(1,1,0,0,1,    1,3,6,0);
        add(1,1,0,0,1,    1,4,7,0);
        add(1,1,0,0,1,    1,5,8,0);
        add(1,1,0,0,1,    1,6,8,0);
        add(1,1,0,0,1,    1,7,8,0);
        add(1,1,0,0,1,    0,0,8,1);
        add(1,1,0,0,1,    0,0,8,1);
        // redirects: out of HALT, with 3 entries queued, and onto END_ADDR
        add(1,1,1,'h100,1, 0,0,'h100,0);
        add(1,1,0,0,1,     1,'h100,'h101,0);
        add(1,1,0,0,1,     1,'h101,'h102,0);
        add(1,1,0,0,0,     1,'h101,'h103,0);
        add(1,1,0,0,0,     1,'h101,'h104,0);
        add(1,1,1,'h120,1, 0,0,'h120,0);
        add(1,1,0,0,1,     1,'h120,'h121,0);
        add(1,1,0,0,1,     1,'h121,'h122,0);
        add(1,1,1,END,1,   0,0,END,1);
        add(1,1,0,0,1,     0,0,END,1);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].start, vecs[i].jen, vecs[i].jt, vecs[i].rdy);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d valid", i), 32'(bus.instr_valid), 32'(vecs[i].ev));
            chk($sformatf("v%0d pc",    i), 32'(bus.instr_pc),    32'(vecs[i].epc));
            chk($sformatf("v%0d out",   i), 32'(bus.instr_out),   32'(vecs[i].eout));
            chk($sformatf("v%0d rom",   i), 32'(bus.rom_addr),    32'(vecs[i].erom));
            chk($sformatf("v%0d done",  i), 32'(bus.fetch_done),  32'(vecs[i].edone));
        end

        // asynchronous reset in mid-stream clears outputs without a clock edge
        drive(1'b1, 1'b1, 1'b1, D'('h10), 1'b1);
        @(posedge clk); @(negedge clk);
        bus.jump_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("async pre valid", 32'(bus.instr_valid), 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async valid", 32'(bus.instr_valid), 32'd0);
        chk("async rom",   32'(bus.rom_addr),    32'd0);
        chk("async pc",    32'(bus.instr_pc),    32'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("post-reset idle rom",   32'(bus.rom_addr),    32'd0);
        chk("post-reset idle valid", 32'(bus.instr_valid), 32'd0);
        bus.start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("restart valid", 32'(bus.instr_valid), 32'd1);
        chk("restart pc",    32'(bus.instr_pc),    32'd0);

`ifdef FETCH_PERF_EN
        // fill, hold full across five edges, then flush four entries
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("perf reset stall", 32'(perf_stall), 32'd0);
        drive(1'b1, 1'b1, 1'b0, '0, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.jump_en = 1'b1;
        bus.jump_target = D'('h30);
        @(posedge clk);
        @(negedge clk);
        bus.jump_en = 1'b0;
        chk("perf stall",   32'(perf_stall),   32'd5);
        chk("perf flushed", 32'(perf_flushed), 32'd4);
        chk("perf fetched", 32'(perf_fetched), 32'd4);
        chk("perf jump valid", 32'(bus.instr_valid), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
